mem_line_adapter: RTL and testbench

//  Downstream neighbour of the L1 cache controller: accepts whole-line read/write requests on the

---
 rtl/mem_line_adapter_if.sv | 32 +++
 rtl/mem_line_adapter.sv | 126 ++++++++++++
 tb/tb_mem_line_adapter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_adapter_if.sv
// mem_line_adapter_if: cache line port (cyc/stb/we/ack) plus narrow physical-memory word port (req/ready).
// slave is the adapter's view; master is the cache controller / memory side.
interface mem_line_adapter_if #(
    parameter int LINE_W = 128,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
);
    logic              cache_cyc;
    logic              cache_stb;
    logic              cache_we;
    logic [ADDR_W-1:0] cache_addr;
    logic [LINE_W-1:0] cache_wdata;
    logic [LINE_W-1:0] cache_rdata;
    logic              cache_ack;
    logic              cache_err;
    logic              pmem_req;
    logic              pmem_we;
    logic [ADDR_W-1:0] pmem_addr;
    logic [WORD_W-1:0] pmem_wdata;
    logic [WORD_W-1:0] pmem_rdata;
    logic              pmem_ready;

    modport slave (
        input  cache_cyc, cache_stb, cache_we, cache_addr, cache_wdata, pmem_rdata, pmem_ready,
        output cache_rdata, cache_ack, cache_err, pmem_req, pmem_we, pmem_addr, pmem_wdata
    );

    modport master (
        output cache_cyc, cache_stb, cache_we, cache_addr, cache_wdata, pmem_rdata, pmem_ready,
        input  cache_rdata, cache_ack, cache_err, pmem_req, pmem_we, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/mem_line_adapter.sv
// mem_line_adapter: serialises whole-line cache fills/write-backs into word bursts on the pmem port.
// Optional per-beat ready timeout enabled by defining MEM_TIMEOUT_EN.
module mem_line_adapter #(
    parameter int LINE_W         = 128,
    parameter int WORD_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rst_n,
    mem_line_adapter_if.slave bus
);
    localparam int BEATS      = LINE_W / WORD_W;
    localparam int WORD_BYTES = WORD_W / 8;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int BW         = BEATS > 1 ? $clog2(BEATS) : 1;

    if (LINE_W % WORD_W != 0 || WORD_W % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("mem_line_adapter: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              we_q, we_d;
    logic              abort_q, abort_d;
    logic              req_q, req_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              last_beat;
    logic              timeout;

    assign last_beat = beat_q == BW'(BEATS - 1);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Counter restarts whenever a new beat is issued (entry into BURST or after each ready).
    always_comb begin
        cnt_d   = (state_q == BURST && !bus.pmem_ready) ? cnt_q + 1'b1 : '0;
        timeout = state_q == BURST && !bus.pmem_ready && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        line_d  = line_q;
        we_d    = we_q;
        abort_d = abort_q;
        req_d   = req_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.cache_cyc && bus.cache_stb) begin
                state_d = BURST;
                beat_d  = '0;
                base_d  = bus.cache_addr & ~ADDR_W'(LINE_BYTES - 1);
                we_d    = bus.cache_we;
                line_d  = bus.cache_we ? bus.cache_wdata : line_q;
                abort_d = 1'b0;
                req_d   = 1'b1;
            end
            BURST: begin
                // A dropped cyc is remembered so the in-flight beat still completes before leaving.
                abort_d = abort_q || !bus.cache_cyc;
                if (bus.pmem_ready) begin
                    if (!we_q) line_d[beat_q*WORD_W +: WORD_W] = bus.pmem_rdata;
                    beat_d  = beat_q + 1'b1;
                    state_d = abort_d ? IDLE : last_beat ? DONE : BURST;
                    req_d   = !(abort_d || last_beat);
                    ack_d   = !abort_d && last_beat;
                end else if (timeout) begin
                    state_d = abort_d ? IDLE : DONE;
                    req_d   = 1'b0;
                    ack_d   = !abort_d;
                    err_d   = !abort_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            line_q  <= '0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            line_q  <= line_d;
            we_q    <= we_d;
            abort_q <= abort_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.cache_rdata = line_q;
    assign bus.cache_ack   = ack_q;
    assign bus.cache_err   = err_q;
    assign bus.pmem_req    = req_q;
    assign bus.pmem_we     = req_q & we_q;
    assign bus.pmem_addr   = base_q + ADDR_W'(beat_q) * ADDR_W'(WORD_BYTES);
    assign bus.pmem_wdata  = line_q[beat_q*WORD_W +: WORD_W];
endmodule

// File: tb/tb_mem_line_adapter.sv
// tb_mem_line_adapter: table-driven line transactions plus directed reset, abort, back-to-back and timeout sequences.
`timescale 1ns/1ps
module tb_mem_line_adapter;
    localparam int LINE_W = 128;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam int TO     = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_line_adapter_if #(.LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    mem_line_adapter #(
        .LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Memory model: every word reads back its own byte address.
    assign bus.pmem_rdata = bus.pmem_addr;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } xfer_t;

    typedef struct {
        string        name;
        logic         we;
        logic [15:0]  addr;
        logic [127:0] wdata;
        int           mode;
        logic [15:0]  base;
        int           ack_at;
        logic [127:0] rdata;
    } vec_t;

    xfer_t xq[$];
    int    ack_seen = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    vec_t  vt[6];

    always @(posedge clk) begin
        if (bus.pmem_req && bus.pmem_ready) xq.push_back('{bus.pmem_addr, bus.pmem_we, bus.pmem_wdata});
        if (bus.cache_ack) ack_seen <= ack_seen + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic rdy(input int mode, input int c);
        return mode == 0 ? 1'b1 : (c % 2) == 0;
    endfunction

    task automatic drive_req(input logic we, input logic [15:0] addr, input logic [127:0] wdata);
        bus.cache_cyc   = 1'b1;
        bus.cache_stb   = 1'b1;
        bus.cache_we    = we;
        bus.cache_addr  = addr;
        bus.cache_wdata = wdata;
    endtask

    task automatic drop_req();
        bus.cache_cyc   = 1'b0;
        bus.cache_stb   = 1'b0;
        bus.cache_we    = 1'b0;
        bus.cache_addr  = 16'hDEAD;
        bus.cache_wdata = '1;
    endtask

    task automatic run_vec(input vec_t v);
        int           got = -1;
        int           x0 = xq.size();
        int           a0 = ack_seen;
        logic [127:0] rd = '0;
        logic         er = 1'b0;
        drive_req(v.we, v.addr, v.wdata);
        bus.pmem_ready = v.mode == 0;
        for (int c = 1; c <= 40 && got < 0; c++) begin
            @(negedge clk);
            if (bus.cache_ack) begin
                got = c;
                rd  = bus.cache_rdata;
                er  = bus.cache_err;
                drop_req();
            end
            bus.pmem_ready = rdy(v.mode, c);
        end
        bus.pmem_ready = 1'b0;
        chk({v.name, "_ack_at"}, 128'(got), 128'(v.ack_at));
        chk({v.name, "_err"}, 128'(er), 128'(0));
        if (!v.we) chk({v.name, "_rdata"}, rd, v.rdata);
        @(negedge clk);
        chk({v.name, "_ack_pulse"}, 128'(bus.cache_ack), 128'(0));
        chk({v.name, "_acks"}, 128'(ack_seen - a0), 128'(1));
        chk({v.name, "_xfers"}, 128'(xq.size() - x0), 128'(8));
        for (int k = 0; k < 8 && x0 + k < xq.size(); k++) begin
            chk($sformatf("%s_beat%0d", v.name, k), {111'(0), xq[x0+k].we, xq[x0+k].addr},
                {111'(0), v.we, v.base + 16'(2 * k)});
            if (v.we) chk($sformatf("%s_wdata%0d", v.name, k), 128'(xq[x0+k].wdata), 128'(v.wdata[k*16 +: 16]));
        end
    endtask

    initial begin
        int a0;
        int x0;
        int acks[$];
        logic req10;
        logic req11;
        drop_req();
        bus.pmem_ready = 1'b0;
        vt[0] = '{"fill_1236", 1'b0, 16'h1236, '0, 0, 16'h1230, 9,
                  128'h123E_123C_123A_1238_1236_1234_1232_1230};
        vt[1] = '{"wb_400a", 1'b1, 16'h400A, 128'hA007_A006_A005_A004_A003_A002_A001_A000, 1, 16'h4000, 17, '0};
        vt[2] = '{"fill_00ff", 1'b0, 16'h00FF, '0, 0, 16'h00F0, 9,
                  128'h00FE_00FC_00FA_00F8_00F6_00F4_00F2_00F0};
        vt[3] = '{"fill_fff1", 1'b0, 16'hFFF1, '0, 1, 16'hFFF0, 17,
                  128'hFFFE_FFFC_FFFA_FFF8_FFF6_FFF4_FFF2_FFF0};
        vt[4] = '{"wb_0010", 1'b1, 16'h0010, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 16'h0010, 9, '0};
        vt[5] = '{"fill_3000", 1'b0, 16'h3000, '0, 0, 16'h3000, 9,
                  128'h300E_300C_300A_3008_3006_3004_3002_3000};

        repeat (2) @(negedge clk);
        chk("rst_ack", 128'(bus.cache_ack), 128'(0));
        chk("rst_req", 128'(bus.pmem_req), 128'(0));
        chk("rst_err", 128'(bus.cache_err), 128'(0));
        chk("rst_rdata", bus.cache_rdata, 128'(0));
        chk("rst_addr", 128'(bus.pmem_addr), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // Asynchronous reset while beat 4 of a fill is on the bus.
        a0 = ack_seen;
        x0 = xq.size();
        drive_req(1'b0, 16'h3000, '0);
        bus.pmem_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_addr", 128'(bus.pmem_addr), 128'(16'h3008));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 128'(bus.pmem_req), 128'(0));
        chk("mid_rst_ack", 128'(bus.cache_ack), 128'(0));
        drop_req();
        bus.pmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_ack", 128'(ack_seen - a0), 128'(0));
        chk("mid_rst_xfers", 128'(xq.size() - x0), 128'(4));
        run_vec(vt[5]);

        // Back-to-back: stb held across the ack, second accept happens in the following IDLE cycle.
        a0 = ack_seen;
        x0 = xq.size();
        req10 = 1'b1;
        req11 = 1'b0;
        drive_req(1'b0, 16'h2000, '0);
        bus.pmem_ready = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 10) req10 = bus.pmem_req;
            if (c == 11) req11 = bus.pmem_req;
            if (bus.cache_ack) begin
                acks.push_back(c);
                if (acks.size() == 2) drop_req();
            end
        end
        bus.pmem_ready = 1'b0;
        chk("b2b_ack_count", 128'(acks.size()), 128'(2));
        chk("b2b_ack1_at", 128'(acks.size() > 0 ? acks[0] : -1), 128'(9));
        chk("b2b_ack2_at", 128'(acks.size() > 1 ? acks[1] : -1), 128'(19));
        chk("b2b_idle_req", 128'(req10), 128'(0));
        chk("b2b_restart_req", 128'(req11), 128'(1));
        chk("b2b_xfers", 128'(xq.size() - x0), 128'(16));
        chk("b2b_second_base", 128'(xq.size() > x0 + 8 ? xq[x0+8].addr : 16'hFFFF), 128'(16'h2000));

        // Abort: cyc dropped during beat 2, ready withheld three cycles.
        a0 = ack_seen;
        x0 = xq.size();
        drive_req(1'b0, 16'h5000, '0);
        bus.pmem_ready = 1'b1;
        repeat (3) @(negedge clk);
        drop_req();
        bus.pmem_ready = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            chk($sformatf("abort_hold_p%0d", c), {111'(0), bus.pmem_req, bus.pmem_addr}, {111'(0), 1'b1, 16'h5004});
            if (c == 6) bus.pmem_ready = 1'b1;
            @(negedge clk);
        end
        bus.pmem_ready = 1'b0;
        chk("abort_req_drop", 128'(bus.pmem_req), 128'(0));
        repeat (10) @(negedge clk);
        chk("abort_no_ack", 128'(ack_seen - a0), 128'(0));
        chk("abort_xfers", 128'(xq.size() - x0), 128'(3));
        chk("abort_last_addr", 128'(xq[xq.size()-1].addr), 128'(16'h5004));
        run_vec(vt[0]);

`ifdef MEM_TIMEOUT_EN
        begin
            int   got = -1;
            logic er = 1'b0;
            logic rq10 = 1'b0;
            x0 = xq.size();
            drive_req(1'b0, 16'h6000, '0);
            bus.pmem_ready = 1'b0;
            for (int c = 1; c <= 30 && got < 0; c++) begin
                @(negedge clk);
                if (c == 10) rq10 = bus.pmem_req;
                if (bus.cache_ack) begin
                    got = c;
                    er  = bus.cache_err;
                    drop_req();
                end
            end
            chk("to_ack_at", 128'(got), 128'(11));
            chk("to_err", 128'(er), 128'(1));
            chk("to_req_before", 128'(rq10), 128'(1));
            chk("to_req_after", 128'(bus.pmem_req), 128'(0));
            @(negedge clk);
            chk("to_ack_pulse", 128'(bus.cache_ack), 128'(0));
            chk("to_xfers", 128'(xq.size() - x0), 128'(0));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end
endmodule
